// File: rtl/control_teclado_matricial_pkg.sv
// teclado_pkg: shared types, constants and helpers for the matrix keypad scanner
package teclado_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} estado_t;
  localparam int CODE_W = 4;
  localparam int N_LINEAS = 4;
  localparam logic [N_LINEAS-1:0] FILA_RESET = 4'b1110;
  // Lowest-index active-low column wins; callers check that at least one is low
  function automatic logic [1:0] col_prioridad(input logic [N_LINEAS-1:0] c);
    return !c[0] ? 2'd0 : !c[1] ? 2'd1 : !c[2] ? 2'd2 : 2'd3;
  endfunction
  // Index of the single low bit of the one-cold row ring
  function automatic logic [1:0] fila_idx(input logic [N_LINEAS-1:0] f);
    return !f[0] ? 2'd0 : !f[1] ? 2'd1 : !f[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/control_teclado_matricial_sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchronizer for asynchronous inputs
module sincronizador_2ff #(
  parameter int W = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [W-1:0] i_D,
  output logic [W-1:0] o_Q
);
  logic [W-1:0] meta_q;
  // Two register stages; reset to the idle (released) level
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      meta_q <= RST_VAL;
      o_Q <= RST_VAL;
    end else begin
      meta_q <= i_D;
      o_Q <= meta_q;
    end
  end
endmodule

// File: rtl/control_teclado_matricial.sv
// control_teclado_matricial: 4x4 keypad scanner with debounce; TECLADO_REPEAT_EN enables auto-repeat
module control_teclado_matricial
  import teclado_pkg::*;
#(
  parameter int PRESC_DIV      = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_TICKS   = 250
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [N_LINEAS-1:0] i_Columnas,
  output logic [N_LINEAS-1:0] o_Filas,
  output logic [CODE_W-1:0]   o_Tecla,
  output logic                o_Valida,
  output logic                o_Presionada
);
  localparam int PW = $clog2(PRESC_DIV);
  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);
  logic [PW-1:0] presc_q;
  logic tick;
  logic [N_LINEAS-1:0] col_s;
  estado_t estado_q;
  logic [N_LINEAS-1:0] filas_q;
  logic [CODE_W-1:0] cand_q, tecla_q;
  logic [3:0] cnt_q, cnt_d;
  logic valida_q, pres_q;
  logic any_low, col_lat_alta, rep_fire;
  logic [1:0] col_min;
  logic [N_LINEAS-1:0] filas_d;

  sincronizador_2ff #(.W(N_LINEAS), .RST_VAL('1)) u_sync (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_D  (i_Columnas),
    .o_Q  (col_s)
  );

  assign tick = presc_q == PW'(PRESC_DIV - 1);
  assign any_low = ~&col_s;
  assign col_min = col_prioridad(col_s);
  assign col_lat_alta = col_s[cand_q[1:0]];
  assign cnt_d = &cnt_q ? cnt_q : cnt_q + 4'd1;
  assign filas_d = {filas_q[N_LINEAS-2:0], filas_q[N_LINEAS-1]};
  assign o_Filas = filas_q;
  assign o_Tecla = tecla_q;
  assign o_Valida = valida_q;
  assign o_Presionada = pres_q;

  // Prescaler: one-cycle tick every PRESC_DIV cycles
  always_ff @(posedge i_Clk) begin
    if (i_Rst || tick) presc_q <= '0;
    else presc_q <= presc_q + PW'(1);
  end

`ifdef TECLADO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] rep_q;
  assign rep_fire = tick && estado_q == HELD && !col_lat_alta && rep_q == RW'(REPEAT_TICKS - 1);
  // Repeat counter: counts held ticks, cleared whenever the key is not in HELD
  always_ff @(posedge i_Clk) begin
    if (i_Rst || estado_q != HELD) rep_q <= '0;
    else if (tick && !col_lat_alta) rep_q <= rep_fire ? '0 : rep_q + RW'(1);
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Scan/debounce FSM with registered outputs; all decisions happen on ticks
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      estado_q <= SCAN;
      filas_q <= FILA_RESET;
      cand_q <= '0;
      cnt_q <= '0;
      tecla_q <= '0;
      valida_q <= 1'b0;
      pres_q <= 1'b0;
    end else begin
      valida_q <= 1'b0;
      if (tick) begin
        case (estado_q)
          SCAN: begin
            if (any_low) begin
              cand_q <= {fila_idx(filas_q), col_min};
              cnt_q <= 4'd1;
              if (DS == 4'd1) begin
                tecla_q <= {fila_idx(filas_q), col_min};
                valida_q <= 1'b1;
                pres_q <= 1'b1;
                estado_q <= HELD;
              end else begin
                estado_q <= DEBOUNCE;
              end
            end else begin
              filas_q <= filas_d;
            end
          end
          DEBOUNCE: begin
            if (any_low && col_min == cand_q[1:0]) begin
              cnt_q <= cnt_d;
              if (cnt_d == DS) begin
                tecla_q <= cand_q;
                valida_q <= 1'b1;
                pres_q <= 1'b1;
                estado_q <= HELD;
              end
            end else begin
              estado_q <= SCAN;
            end
          end
          HELD: begin
            if (col_lat_alta) begin
              cnt_q <= 4'd1;
              if (DS == 4'd1) begin
                pres_q <= 1'b0;
                filas_q <= filas_d;
                estado_q <= SCAN;
              end else begin
                estado_q <= RELEASE;
              end
            end else begin
              valida_q <= rep_fire;
            end
          end
          default: begin
            if (col_lat_alta) begin
              cnt_q <= cnt_d;
              if (cnt_d == DS) begin
                pres_q <= 1'b0;
                filas_q <= filas_d;
                estado_q <= SCAN;
              end
            end else begin
              estado_q <= HELD;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_control_teclado_matricial.sv
// tb_control_teclado_matricial: directed + random keypad stimulus against a tick-level behavioural model
module tb_control_teclado_matricial;
  localparam int PD = 4;
  localparam int DS = 3;
  localparam int RT = 5;

  logic clk = 0;
  logic rst = 1;
  logic [15:0] keys = '0;
  logic [3:0] cols, filas, tecla;
  logic valida, pres;
  int tests = 0;
  int fails = 0;
  int dut_str = 0;
  int mod_str = 0;

  always #5 clk = ~clk;

  control_teclado_matricial #(.PRESC_DIV(PD), .DEBOUNCE_SCANS(DS), .REPEAT_TICKS(RT)) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .i_Columnas(cols),
    .o_Filas(filas),
    .o_Tecla(tecla),
    .o_Valida(valida),
    .o_Presionada(pres)
  );

  // Physical keypad: a column reads low if any pressed key sits on a driven (low) row
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!filas[r] && keys[4*r+c]) cols[c] = 1'b0;
  end

  // Behavioural model, evaluated once per clock, deciding on scan ticks
  int m_row, m_tecla, m_key, m_streak, m_rep, m_phase, m_n;
  bit m_val, m_pres;
  logic [3:0] h1, h2;

  task automatic m_accept();
    m_tecla = m_key; m_val = 1; m_pres = 1; m_phase = 2; m_rep = 0;
  endtask

  task automatic m_release();
    m_pres = 0; m_row = (m_row + 1) % 4; m_phase = 0;
  endtask

  task automatic m_tick(input logic [3:0] seen);
    int low;
    low = -1;
    for (int c = 3; c >= 0; c--) if (!seen[c]) low = c;
    case (m_phase)
      0: if (low >= 0) begin
           m_key = 4 * m_row + low; m_streak = 1;
           if (m_streak >= DS) m_accept(); else m_phase = 1;
         end else m_row = (m_row + 1) % 4;
      1: if (low == m_key % 4) begin
           m_streak++;
           if (m_streak >= DS) m_accept();
         end else m_phase = 0;
      2: if (seen[m_key % 4]) begin
           m_streak = 1;
           if (m_streak >= DS) m_release(); else m_phase = 3;
         end else begin
`ifdef TECLADO_REPEAT_EN
           m_rep++;
           if (m_rep == RT) begin m_val = 1; m_rep = 0; end
`endif
         end
      default: if (seen[m_key % 4]) begin
           if (m_streak < 15) m_streak++;
           if (m_streak >= DS) m_release();
         end else begin m_phase = 2; m_rep = 0; end
    endcase
  endtask

  always @(posedge clk) begin
    logic [3:0] seen;
    if (m_val) mod_str++;
    seen = h2; h2 = h1; h1 = cols;
    if (rst) begin
      m_row = 0; m_tecla = 0; m_val = 0; m_pres = 0; m_n = 0;
      m_phase = 0; m_streak = 0; m_rep = 0; m_key = 0; h1 = 4'hF; h2 = 4'hF;
    end else begin
      m_val = 0; m_n++;
      if (m_n % PD == 0) m_tick(seen);
    end
  end

  always @(posedge clk) if (valida) dut_str++;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    logic [3:0] ef;
    ef = ~(4'b0001 << m_row);
    chk("filas", int'(filas), int'(ef));
    chk("tecla", int'(tecla), m_tecla);
    chk("valida", int'(valida), int'(m_val));
    chk("presionada", int'(pres), int'(m_pres));
  end

  task automatic ticks(input int n);
    repeat (n * PD) @(negedge clk);
  endtask

  task automatic wait_row(input logic [3:0] f);
    int k;
    k = 0;
    while (filas != f && k < 200) begin @(negedge clk); k++; end
    chk("wait_row_timeout", int'(filas), int'(f));
  endtask

  initial begin
    int s0;
    logic [15:0] mask;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_filas", int'(filas), 4'b1110);
    chk("rst_tecla", int'(tecla), 0);
    chk("rst_pres", int'(pres), 0);
    chk("rst_model_row", m_row, 0);
    repeat (PD) @(negedge clk);
    chk("ring1", int'(filas), 4'b1101);
    chk("ring1_model", m_row, 1);
    repeat (PD) @(negedge clk);
    chk("ring2", int'(filas), 4'b1011);
    ticks(2);
    chk("ring4_wrap", int'(filas), 4'b1110);
    chk("idle_no_strobe", dut_str, 0);

    s0 = dut_str;
    keys = 16'h1 << 9;
    ticks(10);
    chk("k9_pres", int'(pres), 1);
    chk("k9_model_pres", int'(m_pres), 1);
    keys = '0;
    ticks(8);
    chk("k9_tecla", int'(tecla), 9);
    chk("k9_model_tecla", m_tecla, 9);
    chk("k9_released", int'(pres), 0);
`ifndef TECLADO_REPEAT_EN
    chk("k9_one_strobe", dut_str - s0, 1);
`endif

    s0 = dut_str;
    wait_row(4'b1011);
    keys = 16'h1 << 9;
    ticks(2);
    keys = '0;
    ticks(1);
    keys = 16'h1 << 9;
    ticks(2);
    chk("bounce_not_yet", dut_str - s0, 0);
    ticks(3);
    keys = '0;
    ticks(6);
    chk("bounce_tecla", int'(tecla), 9);
`ifndef TECLADO_REPEAT_EN
    chk("bounce_one_strobe", dut_str - s0, 1);
`endif

    keys = (16'h1 << 4) | (16'h1 << 7);
    ticks(10);
    keys = '0;
    ticks(8);
    chk("ghost_tecla", int'(tecla), 4);
    chk("ghost_model_tecla", m_tecla, 4);

    s0 = dut_str;
    wait_row(4'b1110);
    keys = 16'h1 << 2;
    repeat (PD) @(negedge clk);
    repeat (PD - 1) @(negedge clk);
    rst = 1;
    keys = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("midrst_filas", int'(filas), 4'b1110);
    chk("midrst_tecla", int'(tecla), 0);
    chk("midrst_pres", int'(pres), 0);
    ticks(6);
    chk("midrst_no_strobe", dut_str - s0, 0);

`ifdef TECLADO_REPEAT_EN
    s0 = dut_str;
    keys = 16'h1 << 15;
    ticks(25);
    keys = '0;
    ticks(8);
    chk("repeat_tecla", int'(tecla), 15);
    chk("repeat_several", int'(dut_str - s0 >= 3), 1);
`endif

    for (int ep = 0; ep < 40; ep++) begin
      mask = 16'h1 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) mask |= 16'h1 << $urandom_range(0, 15);
      for (int c = 0; c < int'($urandom_range(4, 70)); c++) begin
        keys = (c < 10 && $urandom_range(0, 5) == 0) ? 16'h0 : mask;
        if ($urandom_range(0, 400) == 0) rst = 1;
        @(negedge clk);
        rst = 0;
      end
      keys = '0;
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    chk("model_strobe_count", dut_str, mod_str);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
